// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/data memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    localparam int CNT_W = $clog2(16);
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant between fetch and data ports.
// Fixed data priority by default; round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic [1:0] excl,
`ifdef MEM_ARB_RR_EN
    input  owner_t     last_owner,
`endif
    output logic       grant_valid,
    output owner_t     grant_owner
);
    logic i_ok, d_ok;
    assign i_ok = i_req && !excl[0];
    assign d_ok = d_req && !excl[1];
    assign grant_valid = i_ok || d_ok;
`ifdef MEM_ARB_RR_EN
    // On contention the port that did not win last time goes first.
    assign grant_owner = (i_ok && d_ok) ? ((last_owner == OWN_I) ? OWN_D : OWN_I)
                                        : (d_ok ? OWN_D : OWN_I);
`else
    assign grant_owner = d_ok ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin contention resolution instead of data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    state_t            state, state_n;
    owner_t            owner, owner_n, grant_owner;
    logic              grant_valid, grant, last_wait, we, we_n;
    logic              mem_en_n, mem_we_n, i_ack_n, d_ack_n;
    logic [1:0]        excl;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_n, i_rdata_n, d_rdata_n;
`ifdef MEM_ARB_RR_EN
    owner_t            last_owner, last_owner_n;
`endif

    // The port acked in RESP still holds req high, so it is masked out of that arbitration.
    assign excl = (state == RESP) ? ((owner == OWN_D) ? 2'b10 : 2'b01) : 2'b00;

    mem_arb_pick u_pick (
        .i_req,
        .d_req,
        .excl,
`ifdef MEM_ARB_RR_EN
        .last_owner,
`endif
        .grant_valid,
        .grant_owner
    );

    always_comb begin
        grant       = grant_valid && (state == IDLE || state == RESP);
        last_wait   = (state == WAIT) && (cnt == CNT_W'(1));
        state_n     = grant ? ISSUE : (state == ISSUE) ? WAIT : last_wait ? RESP
                    : (state == RESP) ? IDLE : state;
        cnt_n       = (state == ISSUE) ? CNT_W'(MEM_LAT) : (state == WAIT) ? cnt - CNT_W'(1) : cnt;
        owner_n     = grant ? grant_owner : owner;
        we_n        = grant ? (grant_owner == OWN_D && d_we) : we;
        mem_en_n    = grant;
        mem_we_n    = grant && grant_owner == OWN_D && d_we;
        mem_addr_n  = grant ? ((grant_owner == OWN_D) ? d_addr : i_addr) : mem_addr;
        mem_wdata_n = (grant && grant_owner == OWN_D) ? d_wdata : mem_wdata;
        i_ack_n     = last_wait && owner == OWN_I;
        d_ack_n     = last_wait && owner == OWN_D;
        i_rdata_n   = (i_ack_n && !we) ? mem_rdata : i_rdata;
        d_rdata_n   = (d_ack_n && !we) ? mem_rdata : d_rdata;
`ifdef MEM_ARB_RR_EN
        last_owner_n = grant ? grant_owner : last_owner;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            we        <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner <= OWN_I;
`endif
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            we        <= we_n;
            cnt       <= cnt_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            i_ack     <= i_ack_n;
            d_ack     <= d_ack_n;
            i_rdata   <= i_rdata_n;
            d_rdata   <= d_rdata_n;
`ifdef MEM_ARB_RR_EN
            last_owner <= last_owner_n;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT 2, plus 1 and 15 streaming sweeps.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        i_req, d_req, d_we, i_ack, d_ack, mem_en, mem_we;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        sw_i_req[2], sw_d_req[2], sw_i_ack[2], sw_d_ack[2], sw_mem_en[2], sw_mem_we[2];
    logic [31:0] sw_i_addr[2], sw_d_addr[2], sw_i_rdata[2], sw_d_rdata[2];
    logic [31:0] sw_mem_addr[2], sw_mem_wdata[2], sw_mem_rdata[2];

    logic [31:0] st[16];
    logic [31:0] sw_st[2][16];

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    logic seen_i, seen_d;

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A00005 : ((a ^ 32'hA500_0000) + {a[15:0], 16'h0});
    endfunction

    mem_arbiter #(.MEM_LAT(2), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(1), .ADDR_W(32)) u_s1 (
        .clk(clk), .reset(reset),
        .i_req(sw_i_req[0]), .i_addr(sw_i_addr[0]), .i_ack(sw_i_ack[0]), .i_rdata(sw_i_rdata[0]),
        .d_req(sw_d_req[0]), .d_we(1'b0), .d_addr(sw_d_addr[0]), .d_wdata(32'h0),
        .d_ack(sw_d_ack[0]), .d_rdata(sw_d_rdata[0]),
        .mem_en(sw_mem_en[0]), .mem_we(sw_mem_we[0]), .mem_addr(sw_mem_addr[0]),
        .mem_wdata(sw_mem_wdata[0]), .mem_rdata(sw_mem_rdata[0])
    );

    mem_arbiter #(.MEM_LAT(15), .ADDR_W(32)) u_s15 (
        .clk(clk), .reset(reset),
        .i_req(sw_i_req[1]), .i_addr(sw_i_addr[1]), .i_ack(sw_i_ack[1]), .i_rdata(sw_i_rdata[1]),
        .d_req(sw_d_req[1]), .d_we(1'b0), .d_addr(sw_d_addr[1]), .d_wdata(32'h0),
        .d_ack(sw_d_ack[1]), .d_rdata(sw_d_rdata[1]),
        .mem_en(sw_mem_en[1]), .mem_we(sw_mem_we[1]), .mem_addr(sw_mem_addr[1]),
        .mem_wdata(sw_mem_wdata[1]), .mem_rdata(sw_mem_rdata[1])
    );

    // Fixed-latency memories: read data appears only in the cycle it is due, else a marker.
    assign mem_rdata       = st[1];
    assign sw_mem_rdata[0] = sw_st[0][0];
    assign sw_mem_rdata[1] = sw_st[1][14];

    always @(posedge clk) begin
        for (int k = 15; k > 0; k--) begin
            st[k]       <= st[k-1];
            sw_st[0][k] <= sw_st[0][k-1];
            sw_st[1][k] <= sw_st[1][k-1];
        end
        st[0] <= (mem_en && !mem_we) ? model(mem_addr) : 32'hDEAD_BEEF;
        for (int s = 0; s < 2; s++)
            sw_st[s][0] <= (sw_mem_en[s] && !sw_mem_we[s]) ? model(sw_mem_addr[s]) : 32'hDEAD_BEEF;
    end

    task automatic begin_txn();
        @(posedge clk);
        #1;
        cyc = 0;
        seen_i = 1'b0;
        seen_d = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (seen_i) i_req = 1'b0;
        if (seen_d) d_req = 1'b0;
        cyc++;
        @(negedge clk);
        seen_i = i_ack;
        seen_d = d_ack;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got %h want 0",
                     {i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        n_checks++;
        if ({sw_mem_en[0], sw_mem_en[1], sw_i_ack[0], sw_i_ack[1]} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_sweep got %b want 0", {sw_mem_en[0], sw_mem_en[1], sw_i_ack[0], sw_i_ack[1]});
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        begin_txn();
        i_req = 1'b1;
        i_addr = 32'h10;
        repeat (5) begin
            step();
            n_checks++;
            if ({i_ack, d_ack} !== {cyc == 4, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_ack cyc %0d got %b want %b", cyc, {i_ack, d_ack}, {cyc == 4, 1'b0});
            end
            if (cyc == 1) begin
                n_checks++;
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
                    n_fail++;
                    $display("FAIL fetch_issue got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h10});
                end
            end
            if (cyc == 2) begin
                n_checks++;
                if (mem_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_en_pulse got %b want 0", mem_en);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (i_rdata !== 32'hE3A00005) begin
                    n_fail++;
                    $display("FAIL fetch_rdata got %h want e3a00005", i_rdata);
                end
            end
        end
    endtask

    task automatic test_data_write();
        begin_txn();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h64;
        d_wdata = 32'd7;
        repeat (5) begin
            step();
            n_checks++;
            if ({i_ack, d_ack} !== {1'b0, cyc == 4}) begin
                n_fail++;
                $display("FAIL write_ack cyc %0d got %b want %b", cyc, {i_ack, d_ack}, {1'b0, cyc == 4});
            end
            if (cyc == 1) begin
                n_checks++;
                if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h64, 32'd7}) begin
                    n_fail++;
                    $display("FAIL write_issue got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata},
                             {1'b1, 1'b1, 32'h64, 32'd7});
                end
            end
            if (cyc == 2) begin
                n_checks++;
                if ({mem_en, mem_we} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL write_strobe_pulse got %b want 00", {mem_en, mem_we});
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if ({d_rdata, i_rdata} !== {32'h0, 32'hE3A00005}) begin
                    n_fail++;
                    $display("FAIL write_rdata_hold got %h want %h", {d_rdata, i_rdata}, {32'h0, 32'hE3A00005});
                end
            end
        end
        d_we = 1'b0;
    endtask

    task automatic test_data_read();
        begin_txn();
        d_req = 1'b1;
        d_addr = 32'h80;
        repeat (5) begin
            step();
            n_checks++;
            if ({i_ack, d_ack} !== {1'b0, cyc == 4}) begin
                n_fail++;
                $display("FAIL read_ack cyc %0d got %b want %b", cyc, {i_ack, d_ack}, {1'b0, cyc == 4});
            end
            if (cyc == 1) begin
                n_checks++;
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
                    n_fail++;
                    $display("FAIL read_issue got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h80});
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (d_rdata !== model(32'h80)) begin
                    n_fail++;
                    $display("FAIL read_rdata got %h want %h", d_rdata, model(32'h80));
                end
            end
        end
    endtask

    task automatic test_contention();
        logic first_d;
        logic [1:0] want;
`ifdef MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        begin_txn();
        i_req = 1'b1;
        i_addr = 32'h20;
        d_req = 1'b1;
        d_addr = 32'h40;
        repeat (9) begin
            step();
            want = (cyc == 4) ? (first_d ? 2'b01 : 2'b10) : (cyc == 8) ? (first_d ? 2'b10 : 2'b01) : 2'b00;
            n_checks++;
            if ({i_ack, d_ack} !== want) begin
                n_fail++;
                $display("FAIL contention_ack cyc %0d got %b want %b", cyc, {i_ack, d_ack}, want);
            end
            if (cyc == 1 || cyc == 5) begin
                n_checks++;
                if ({mem_en, mem_addr} !== {1'b1, ((cyc == 1) == first_d) ? 32'h40 : 32'h20}) begin
                    n_fail++;
                    $display("FAIL contention_issue cyc %0d got %h", cyc, {mem_en, mem_addr});
                end
            end
            if (cyc == 4 || cyc == 8) begin
                n_checks++;
                if (((cyc == 4) == first_d) ? (d_rdata !== model(32'h40)) : (i_rdata !== model(32'h20))) begin
                    n_fail++;
                    $display("FAIL contention_rdata cyc %0d got i=%h d=%h want i=%h d=%h", cyc, i_rdata, d_rdata,
                             model(32'h20), model(32'h40));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        begin_txn();
        i_req = 1'b1;
        i_addr = 32'h30;
        step();
        step();
        #1;
        reset = 1'b0;
        i_req = 1'b0;
        #1;
        n_checks++;
        if ({i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_values got %h want 0",
                     {i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) begin
            step();
            n_checks++;
            if ({i_ack, d_ack, mem_en, i_rdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_abandon cyc %0d got %h want 0", cyc, {i_ack, d_ack, mem_en, i_rdata});
            end
        end
    endtask

    task automatic test_back_to_back(input int s, input int lat, input int n_acks);
        int acks, last_c, c;
        logic [31:0] ia, da;
        logic si, sd;
        acks = 0;
        last_c = 0;
        c = 0;
        si = 1'b0;
        sd = 1'b0;
        ia = 32'h1000 + 32'(s) * 32'h100;
        da = 32'h2000 + 32'(s) * 32'h100;
        @(posedge clk);
        #1;
        sw_i_addr[s] = ia;
        sw_d_addr[s] = da;
        sw_i_req[s] = 1'b1;
        sw_d_req[s] = 1'b1;
        while (acks < n_acks && c < n_acks * (lat + 2) + 10) begin
            @(posedge clk);
            #1;
            c++;
            if (si) begin
                ia += 32'h4;
                sw_i_addr[s] = ia;
            end
            if (sd) begin
                da += 32'h4;
                sw_d_addr[s] = da;
            end
            @(negedge clk);
            si = sw_i_ack[s];
            sd = sw_d_ack[s];
            if (si || sd) begin
                n_checks++;
                if ((si && sd) || (c - last_c != lat + 2)) begin
                    n_fail++;
                    $display("FAIL sweep%0d_spacing got %0d cycles (i=%b d=%b) want %0d", lat, c - last_c, si, sd, lat + 2);
                end
                n_checks++;
                if (si ? (sw_i_rdata[s] !== model(ia)) : (sw_d_rdata[s] !== model(da))) begin
                    n_fail++;
                    $display("FAIL sweep%0d_rdata got i=%h d=%h want i=%h d=%h", lat, sw_i_rdata[s], sw_d_rdata[s],
                             model(ia), model(da));
                end
                last_c = c;
                acks++;
            end
        end
        n_checks++;
        if (acks != n_acks) begin
            n_fail++;
            $display("FAIL sweep%0d_count got %0d want %0d", lat, acks, n_acks);
        end
    endtask

    initial begin
        i_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        for (int s = 0; s < 2; s++) begin
            sw_i_req[s] = 1'b0;
            sw_d_req[s] = 1'b0;
            sw_i_addr[s] = '0;
            sw_d_addr[s] = '0;
        end
        test_reset();
        test_single_fetch();
        test_data_write();
        test_data_read();
        test_contention();
        test_reset_mid();
        test_back_to_back(0, 1, 8);
        test_back_to_back(1, 15, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares a single-port, fixed-latency unified memory between the fetch stage (instruction port) and the memory stage (data port) of the pipelined ARM core. It sits between the core and the unified memory, serialising requests through a four-state FSM and returning one-cycle acknowledge pulses. The core holds `PCF` or `ALUOutM` stable and stalls the affected stage until the port's ack arrives.

## Interface
- `MEM_LAT`, 2, memory read latency in cycles after the sampling edge of `mem_en`; legal range 1..15
- `ADDR_W`, 32, address width
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `i_req`  in  1  fetch request; held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_ack`  out  1  one-cycle pulse; `i_rdata` valid in the same cycle
- `i_rdata`  out  32  fetched instruction
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  32  write data
- `d_ack`  out  1  one-cycle completion pulse
- `d_rdata`  out  32  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data, valid `MEM_LAT` cycles after the edge that samples `mem_en`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, pick an owner, latch owner/addr/we/wdata, go to ISSUE; otherwise stay.
- ISSUE (1 cycle): `mem_en`=1, `mem_we`=owner is D and `d_we`; load the counter with `MEM_LAT`; go to WAIT.
- WAIT (`MEM_LAT` cycles): decrement; in the last WAIT cycle capture `mem_rdata` into the owner's rdata register (reads only); go to RESP.
- RESP (1 cycle): pulse the owner's ack. Arbitrate in the same cycle, excluding the just-acked port, whose req is still high. If the other port requests, go directly to ISSUE; else go to IDLE.
- Priority: D wins when both ports request (the older instruction).
- Writes update neither rdata register. `i_rdata`/`d_rdata` otherwise hold their last values.
- Dropping `req` before ack is illegal; behaviour is unspecified and not checked.
- Reset (any time, including mid-transaction): state goes to IDLE and the in-flight access is abandoned. Any later `mem_rdata` for it is ignored.
- Reset values: all acks 0, `mem_en`/`mem_we` 0, `mem_addr`/`mem_wdata` 0, `i_rdata`/`d_rdata` 0.

## Timing
- Request first seen in IDLE in cycle T: `mem_en` in T+1, data captured in T+1+`MEM_LAT`, ack in T+2+`MEM_LAT`.
- `MEM_LAT`=2 gives a 4-cycle request-to-ack latency.
- Back-to-back transactions through RESP→ISSUE: one transaction per `MEM_LAT`+2 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `MEM_ARB_RR_EN`: when defined, contention (both ports requesting in IDLE or RESP) is resolved round-robin. A `last_owner` register (reset value I) decides; the port not granted last wins.
- Undefined: fixed D priority as described in Operation. The `last_owner` register is not present.
- RESP exclusion of the acked port applies in both modes.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - owner enum (OWN_I, OWN_D)
  - counter width localparam `$clog2(16)`
- Sub-module `mem_arb_pick` (combinational): inputs `i_req`, `d_req`, exclude mask, `last_owner`; outputs `grant_valid`, `grant_owner`. It contains the priority or round-robin selection, switched by `MEM_ARB_RR_EN`.

## Test plan
- Single fetch, `MEM_LAT`=2: `i_req`=1, `i_addr`=0x10 at cycle 0; memory returns 0xE3A00005 → `mem_en`=1 with `mem_addr`=0x10 in cycle 1, `i_ack`=1 with `i_rdata`=0xE3A00005 in cycle 4, `d_ack` never pulses.
- Data write: `d_req`=1, `d_we`=1, `d_addr`=0x64, `d_wdata`=7 → `mem_we`=1, `mem_addr`=0x64, `mem_wdata`=7 in cycle 1; `d_ack` in cycle 4; `d_rdata` unchanged.
- Contention: `i_req` and `d_req` both raised in cycle 0 → D served first with `d_ack` in cycle 4; I issued in cycle 5 via RESP→ISSUE with `i_ack` in cycle 8.
  - With `MEM_ARB_RR_EN` and `last_owner`=D: I is served first instead.
- Reset mid-transaction: assert `reset`=0 in a WAIT cycle → outputs go to reset values immediately; after release, no ack pulses for the abandoned access.
- `MEM_LAT`=1 and `MEM_LAT`=15 sweeps with a continuous fetch stream → acks every 3 and every 17 cycles respectively, and each `i_rdata` matches the memory model.
